// File: rtl/sdram_port_arbiter_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states, port indices and grant helpers.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam logic [1:0] PORT_DMA    = 2'd0;
  localparam logic [1:0] PORT_ICACHE = 2'd1;
  localparam logic [1:0] PORT_DCACHE = 2'd2;
  localparam logic [1:0] NO_GRANT    = 2'd3;

  function automatic logic [1:0] onehot_to_port(input logic [2:0] oh);
    logic [1:0] p;
    p = NO_GRANT;
    if (oh[0])      p = PORT_DMA;
    else if (oh[1]) p = PORT_ICACHE;
    else if (oh[2]) p = PORT_DCACHE;
    return p;
  endfunction

  function automatic logic [2:0] port_to_onehot(input logic [1:0] p);
    logic [2:0] oh;
    oh = 3'b000;
    if (p != NO_GRANT) oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Winner selection: DMA port has fixed priority, the two cache ports alternate on a tie.
module rr_priority_pick
  import sdram_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_last,
  output logic [2:0] winner
);

  always_comb begin
    winner = 3'b000;
    if (req[PORT_DMA])
      winner = 3'b001;
    else if (req[PORT_ICACHE] && req[PORT_DCACHE])
      winner = (rr_last == PORT_ICACHE) ? 3'b100 : 3'b010;
    else if (req[PORT_ICACHE])
      winner = 3'b010;
    else if (req[PORT_DCACHE])
      winner = 3'b100;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between DMA and two cache requesters, one transaction at a time.
//   state      | meaning
//   ST_IDLE    | no grant; pick a winner from req_i and latch its request into ctl_*
//   ST_BUSY    | transaction in flight; fills/ack routed to the granted port
//   ST_RELEASE | one gap cycle so the finished port's req is seen low before re-arbitration
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_i,
  input  logic [2:0]        rw_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [15:0]       wdata0_i,
  input  logic [15:0]       wdata1_i,
  input  logic [15:0]       wdata2_i,
  output logic [2:0]        fill_o,
  output logic [2:0]        ack_o,
  output logic [15:0]       rdata_o,
  output logic              ctl_req,
  output logic              ctl_rw,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [15:0]       ctl_wdata,
  input  logic              ctl_fill,
  input  logic              ctl_ack,
  input  logic [15:0]       ctl_rdata
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  arb_state_t       state;
  logic [1:0]       grant;
  logic [1:0]       rr_last;
  logic [CNT_W-1:0] fill_cnt;
  logic [2:0]       winner;
  logic [2:0]       grant_oh;

  rr_priority_pick u_pick (
    .req     (req_i),
    .rr_last (rr_last),
    .winner  (winner)
  );

  // Strobes are combinational so the cache captures data in the same cycle as ctl_fill.
  assign grant_oh = port_to_onehot(grant);
  assign rdata_o  = ctl_rdata;
  assign fill_o   = (state == ST_BUSY && ctl_rw)  ? (grant_oh & {3{ctl_fill}}) : 3'b000;
  assign ack_o    = (state == ST_BUSY && !ctl_rw) ? (grant_oh & {3{ctl_ack}})  : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= NO_GRANT;
      rr_last   <= PORT_DCACHE;
      fill_cnt  <= '0;
      ctl_req   <= 1'b0;
      ctl_rw    <= 1'b1;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            grant   <= onehot_to_port(winner);
            ctl_req <= 1'b1;
            state   <= ST_BUSY;
            case (winner)
              3'b010: begin
                ctl_addr  <= addr1_i;
                ctl_wdata <= wdata1_i;
                ctl_rw    <= rw_i[1];
              end
              3'b100: begin
                ctl_addr  <= addr2_i;
                ctl_wdata <= wdata2_i;
                ctl_rw    <= rw_i[2];
              end
              default: begin
                ctl_addr  <= addr0_i;
                ctl_wdata <= wdata0_i;
                ctl_rw    <= rw_i[0];
              end
            endcase
          end
        end
        ST_BUSY: begin
          if (ctl_rw) begin
            if (ctl_fill) begin
              ctl_req <= 1'b0;
              if (fill_cnt == CNT_W'(BURST_LEN - 1)) begin
                fill_cnt <= '0;
                state    <= ST_RELEASE;
              end else begin
                fill_cnt <= fill_cnt + 1'b1;
              end
            end
          end else if (ctl_ack) begin
            ctl_req <= 1'b0;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (grant == PORT_ICACHE || grant == PORT_DCACHE)
            rr_last <= grant;
          grant <= NO_GRANT;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: request rounds, a randomized controller model, and a monitor.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_i = '0, rw_i = '0;
  logic [31:0] addr0_i = '0, addr1_i = '0, addr2_i = '0;
  logic [15:0] wdata0_i = '0, wdata1_i = '0, wdata2_i = '0;
  logic [2:0]  fill_o, ack_o;
  logic [15:0] rdata_o;
  logic        ctl_req, ctl_rw;
  logic [31:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic        ctl_fill = 1'b0, ctl_ack = 1'b0;
  logic [15:0] ctl_rdata = '0;

  int n_vec = 0, n_err = 0;

  typedef struct {
    int          port;
    bit          rw;
    logic [31:0] addr;
    logic [15:0] wdata;
  } item_t;

  item_t       sb[$];
  int          rr_m = 2;
  logic [2:0]  r_rw;
  logic [31:0] r_addr[3];
  logic [15:0] r_wd[3];

  bit          mon_active = 0, prev_req = 0, chk_low = 0;
  item_t       cur;
  int          fills = 0;
  logic [2:0]  exp_fill, exp_ack;

  int c_mode = 0, c_wait = 0, c_left = 0;
  bit c_rw = 0, stray_en = 0, force_stray = 0;

  sdram_port_arbiter #(.BURST_LEN(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .rw_i(rw_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .addr2_i(addr2_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .wdata2_i(wdata2_i),
    .fill_o(fill_o), .ack_o(ack_o), .rdata_o(rdata_o),
    .ctl_req(ctl_req), .ctl_rw(ctl_rw), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_fill(ctl_fill), .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: DMA first, then the cache port that was not served last, then the other.
  function automatic void push_port(input int p);
    item_t it;
    it.port  = p;
    it.rw    = r_rw[p];
    it.addr  = r_addr[p];
    it.wdata = r_wd[p];
    sb.push_back(it);
  endfunction

  task automatic model_round(input logic [2:0] s);
    int first;
    if (s[0]) push_port(0);
    if (s[1] && s[2]) begin
      first = (rr_m == 1) ? 2 : 1;
      push_port(first);
      push_port(3 - first);
      rr_m = 3 - first;
    end else if (s[1]) begin
      push_port(1);
      rr_m = 1;
    end else if (s[2]) begin
      push_port(2);
      rr_m = 2;
    end
  endtask

  // Controller model: responds to ctl_req after a random delay, optionally injects stray strobes.
  always @(negedge clk) begin
    ctl_fill = 1'b0;
    ctl_ack  = 1'b0;
    if (reset) begin
      c_mode = 0;
    end else if (c_mode == 0) begin
      if (ctl_req) begin
        c_rw   = ctl_rw;
        c_left = c_rw ? 4 : 1;
        c_wait = $urandom_range(0, 3);
        c_mode = 1;
      end else if (force_stray || (stray_en && $urandom_range(0, 5) == 0)) begin
        ctl_fill = 1'b1;
        ctl_ack  = 1'b1;
      end
    end else if (c_wait != 0) begin
      c_wait--;
      if (stray_en && $urandom_range(0, 3) == 0) begin
        if (c_rw) ctl_ack = 1'b1;
        else      ctl_fill = 1'b1;
      end
    end else begin
      if (c_rw) begin
        ctl_fill  = 1'b1;
        ctl_rdata = 16'($urandom);
      end else begin
        ctl_ack = 1'b1;
      end
      c_left--;
      if (c_left == 0) c_mode = 0;
      else             c_wait = $urandom_range(0, 3);
    end
  end

  // Monitor: pops an expected transaction on each new ctl_req and checks routing of strobes.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      mon_active = 0;
      prev_req   = 0;
      chk_low    = 0;
    end else begin
      if (chk_low) begin
        chk("ctl_req_drop", ctl_req, 0);
        chk_low = 0;
      end
      if (ctl_req && !prev_req) begin
        chk("grant_overlap", mon_active, 0);
        chk("grant_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur        = sb.pop_front();
          mon_active = 1;
          fills      = 0;
          chk("ctl_rw", ctl_rw, cur.rw);
          chk("ctl_addr", ctl_addr, cur.addr);
          chk("ctl_wdata", ctl_wdata, cur.wdata);
        end
      end
      exp_fill = (mon_active && cur.rw && ctl_fill)  ? 3'(1 << cur.port) : 3'b000;
      exp_ack  = (mon_active && !cur.rw && ctl_ack)  ? 3'(1 << cur.port) : 3'b000;
      if (ctl_fill || ctl_ack || fill_o != 0 || ack_o != 0) begin
        chk("fill_o", fill_o, exp_fill);
        chk("ack_o", ack_o, exp_ack);
      end
      if (exp_fill != 0) begin
        chk("rdata_o", rdata_o, ctl_rdata);
        if (fills == 0) chk_low = 1;
        fills++;
        if (fills == 4) mon_active = 0;
      end
      if (exp_ack != 0) begin
        chk_low    = 1;
        mon_active = 0;
      end
      prev_req = ctl_req;
    end
  end

  task automatic drive_ports(input logic [2:0] s);
    rw_i     = r_rw;
    addr0_i  = r_addr[0];
    addr1_i  = r_addr[1];
    addr2_i  = r_addr[2];
    wdata0_i = r_wd[0];
    wdata1_i = r_wd[1];
    wdata2_i = r_wd[2];
    req_i    = s;
  endtask

  // Requesters hold req until their first fill or ack, then drop it at the next negedge.
  task automatic run_round(input logic [2:0] s);
    logic [2:0] drop;
    bit done;
    drop = '0;
    done = 0;
    model_round(s);
    @(negedge clk);
    drive_ports(s);
    #4;
    chk("req_lat0", ctl_req, 0);
    @(negedge clk);
    #4;
    chk("req_lat1", ctl_req, 1);
    drop |= fill_o | ack_o;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      req_i &= ~drop;
      #4;
      drop |= fill_o | ack_o;
      if (sb.size() == 0 && !mon_active && req_i == 0) done = 1;
    end
    chk("round_done", done, 1);
    repeat (2) @(negedge clk);
    req_i = '0;
  endtask

  task automatic rand_ports();
    for (int p = 0; p < 3; p++) begin
      r_addr[p] = $urandom;
      r_wd[p]   = 16'($urandom);
    end
    r_rw = 3'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl_req"}, ctl_req, 0);
    chk({tag, "_ctl_rw"}, ctl_rw, 1);
    chk({tag, "_ctl_addr"}, ctl_addr, 0);
    chk({tag, "_ctl_wdata"}, ctl_wdata, 0);
    chk({tag, "_fill_o"}, fill_o, 0);
    chk({tag, "_ack_o"}, ack_o, 0);
  endtask

  initial begin
    logic [2:0] drop;
    int nf;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    force_stray = 1;
    repeat (3) @(negedge clk);
    force_stray = 0;

    r_rw = 3'b010;
    r_addr[0] = 32'h10; r_addr[1] = 32'h100; r_addr[2] = 32'h200;
    r_wd[0] = 16'h1111; r_wd[1] = 16'h2222; r_wd[2] = 16'h3333;
    run_round(3'b010);

    r_rw = 3'b000;
    r_addr[2] = 32'h2000; r_wd[2] = 16'hBEEF;
    run_round(3'b100);

    stray_en = 1;
    r_rw = 3'b111;
    r_addr[0] = 32'hA0; r_addr[1] = 32'hA1; r_addr[2] = 32'hA2;
    run_round(3'b111);
    run_round(3'b111);
    run_round(3'b110);

    for (int i = 0; i < 40; i++) begin
      rand_ports();
      run_round(3'($urandom_range(1, 7)));
    end

    // Reset after the second fill word of a port-2 burst.
    stray_en = 0;
    r_rw = 3'b100;
    r_addr[2] = 32'hCAFE_0000;
    model_round(3'b100);
    @(negedge clk);
    drive_ports(3'b100);
    drop = '0;
    nf = 0;
    for (int cyc = 0; cyc < 200 && nf < 2; cyc++) begin
      @(negedge clk);
      req_i &= ~drop;
      #4;
      if (fill_o != 0) begin
        nf++;
        drop |= fill_o;
      end
    end
    chk("reset_wait_fills", nf, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_i = '0;
    sb.delete();
    rr_m = 2;
    @(negedge clk);
    #4;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    r_rw = 3'b011;
    r_addr[0] = 32'h55; r_addr[1] = 32'h66; r_addr[2] = 32'h77;
    run_round(3'b110);
    stray_en = 1;
    for (int i = 0; i < 10; i++) begin
      rand_ports();
      run_round(3'($urandom_range(1, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
